// File: rtl/if_fetch_if.sv
//------------------------------------------------------------------------------
// if_fetch_if : redirect, memory and IF/ID handshake bundle for the fetch stage
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface if_fetch_if #(
  parameter int PC_W   = 64,
  parameter int INST_W = 32
);
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              req_valid;
  logic              req_ready;
  logic [PC_W-1:0]   req_addr;
  logic              resp_valid;
  logic [INST_W-1:0] resp_data;
  logic              resp_ready;
  logic              pc_valid;
  logic              if_ready;
  logic [PC_W-1:0]   IF_pc;
  logic [INST_W-1:0] IF_instr;

  // master is the fetch unit; slave is the memory/pipeline environment
  modport master (
    input  redirect_valid, redirect_pc, req_ready, resp_valid, resp_data, if_ready,
    output req_valid, req_addr, resp_ready, pc_valid, IF_pc, IF_instr
  );

  modport slave (
    output redirect_valid, redirect_pc, req_ready, resp_valid, resp_data, if_ready,
    input  req_valid, req_addr, resp_ready, pc_valid, IF_pc, IF_instr
  );
endinterface

`default_nettype wire

// File: rtl/if_fetch.sv
//------------------------------------------------------------------------------
// if_fetch : REQ/WAIT/HOLD instruction fetch FSM, one outstanding request
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module if_fetch #(
  parameter int              PC_W     = 64,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic          clock,
  input  logic          reset,
  if_fetch_if.master    bus
);

  localparam logic [INST_W-1:0] NOP_INSTR = INST_W'(32'h0000_0013);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              kill_q, kill_d;
  logic [PC_W-1:0]   if_pc_q, if_pc_d;
  logic [INST_W-1:0] if_instr_q, if_instr_d;
  logic              req_valid_q;
  logic              resp_ready_q;
  logic              pc_valid_q;
  logic [PC_W-1:0]   redirect_target;

  assign redirect_target = {bus.redirect_pc[PC_W-1:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    case (state_q)
      ST_REQ: begin
        if (bus.redirect_valid) pc_d = redirect_target;
        // req_valid_q is low for the first cycle out of reset, so no accept there
        if (req_valid_q && bus.req_ready) begin
          state_d = ST_WAIT;
          kill_d  = bus.redirect_valid;
        end
      end
      ST_WAIT: begin
        if (bus.redirect_valid) pc_d = redirect_target;
        if (bus.resp_valid) begin
          if (kill_q || bus.redirect_valid) begin
            state_d = ST_REQ;
            kill_d  = 1'b0;
          end else begin
            state_d    = ST_HOLD;
            if_pc_d    = pc_q;
            if_instr_d = bus.resp_data;
          end
        end else if (bus.redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (bus.redirect_valid) begin
          pc_d    = redirect_target;
          state_d = ST_REQ;
        end else if (bus.if_ready) begin
          pc_d    = pc_q + PC_W'(4);
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      if_pc_q      <= '0;
      if_instr_q   <= NOP_INSTR;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b0;
      pc_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
      req_valid_q  <= (state_d == ST_REQ);
      resp_ready_q <= (state_d == ST_WAIT);
      pc_valid_q   <= (state_d == ST_HOLD);
    end
  end

  assign bus.req_valid  = req_valid_q;
  assign bus.req_addr   = pc_q;
  assign bus.resp_ready = resp_ready_q;
  assign bus.pc_valid   = pc_valid_q;
  assign bus.IF_pc      = if_pc_q;
  assign bus.IF_instr   = if_instr_q;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
//------------------------------------------------------------------------------
// tb_if_fetch : directed vector table, corner sequences and random scoreboard
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_if_fetch;

  localparam logic [63:0] B   = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [63:0] rpc;
    logic        rq;
    logic        rsv;
    logic [31:0] rsd;
    logic        ifr;
    logic        e_reqv;
    logic [63:0] e_addr;
    logic        e_rspr;
    logic        e_pcv;
    logic [63:0] e_ifpc;
    logic [31:0] e_instr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  if_fetch_if #(.PC_W(64), .INST_W(32)) bus ();

  if_fetch #(.PC_W(64), .INST_W(32), .RESET_PC(B)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  function automatic vec_t v(input logic r, input logic rv, input logic [63:0] rpc,
                             input logic rq, input logic rsv, input logic [31:0] rsd,
                             input logic ifr, input logic ereqv, input logic [63:0] eaddr,
                             input logic erspr, input logic epcv, input logic [63:0] eifpc,
                             input logic [31:0] einstr);
    vec_t t;
    t.rst = r; t.rv = rv; t.rpc = rpc; t.rq = rq; t.rsv = rsv; t.rsd = rsd; t.ifr = ifr;
    t.e_reqv = ereqv; t.e_addr = eaddr; t.e_rspr = erspr; t.e_pcv = epcv;
    t.e_ifpc = eifpc; t.e_instr = einstr;
    return t;
  endfunction

  // Instruction word the random-phase memory returns for a given address
  function automatic logic [31:0] memf(input logic [63:0] a);
    return a[31:0] ^ {a[47:32], a[63:48]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rv, input logic [63:0] rpc, input logic rq,
                       input logic rsv, input logic [31:0] rsd, input logic ifr);
    rst                = r;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.req_ready      = rq;
    bus.resp_valid     = rsv;
    bus.resp_data      = rsd;
    bus.if_ready       = ifr;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    logic [63:0] exp_pc;
    logic        pending;
    logic [63:0] pend_addr;
    int          retired;

    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);

    // Each row: inputs held for one cycle, then outputs after that rising edge
    vecs.push_back(v(1,0,0,0,0,0,0,                  0,B,0,0,0,NOP));
    vecs.push_back(v(1,0,0,1,1,32'hDEADBEEF,1,       0,B,0,0,0,NOP));
    vecs.push_back(v(0,0,0,1,0,0,1,                  1,B,0,0,0,NOP));
    vecs.push_back(v(0,0,0,1,0,0,1,                  0,B,1,0,0,NOP));
    vecs.push_back(v(0,0,0,0,1,32'h00100093,1,       0,B,0,1,B,32'h00100093));
    vecs.push_back(v(0,0,0,0,0,0,1,                  1,B+4,0,0,B,32'h00100093));
    vecs.push_back(v(0,0,0,1,0,0,0,                  0,B+4,1,0,B,32'h00100093));
    vecs.push_back(v(0,0,0,0,1,32'h00200113,0,       0,B+4,0,1,B+4,32'h00200113));
    for (int k = 0; k < 5; k++)
      vecs.push_back(v(0,0,0,1,1,32'hDEADBEEF,0,     0,B+4,0,1,B+4,32'h00200113));
    vecs.push_back(v(0,0,0,0,0,0,1,                  1,B+8,0,0,B+4,32'h00200113));
    vecs.push_back(v(0,0,0,1,0,0,0,                  0,B+8,1,0,B+4,32'h00200113));
    vecs.push_back(v(0,1,64'h80001002,0,0,0,0,       0,64'h80001000,1,0,B+4,32'h00200113));
    vecs.push_back(v(0,0,0,0,1,32'h11111111,0,       1,64'h80001000,0,0,B+4,32'h00200113));
    vecs.push_back(v(0,0,0,1,0,0,0,                  0,64'h80001000,1,0,B+4,32'h00200113));
    vecs.push_back(v(0,0,0,0,1,32'h00300193,0,       0,64'h80001000,0,1,64'h80001000,32'h00300193));
    vecs.push_back(v(0,1,64'h80000100,0,0,0,1,       1,64'h80000100,0,0,64'h80001000,32'h00300193));
    vecs.push_back(v(0,1,64'h80000203,1,0,0,0,       0,64'h80000200,1,0,64'h80001000,32'h00300193));
    vecs.push_back(v(0,0,0,0,1,32'h44444444,0,       1,64'h80000200,0,0,64'h80001000,32'h00300193));
    vecs.push_back(v(0,0,0,1,0,0,0,                  0,64'h80000200,1,0,64'h80001000,32'h00300193));
    vecs.push_back(v(0,1,64'h80000300,0,1,32'h00400213,0, 1,64'h80000300,0,0,64'h80001000,32'h00300193));
    vecs.push_back(v(0,0,0,1,0,0,0,                  0,64'h80000300,1,0,64'h80001000,32'h00300193));
    vecs.push_back(v(1,0,0,0,0,0,0,                  0,B,0,0,0,NOP));
    vecs.push_back(v(0,0,0,0,1,32'h55555555,0,       1,B,0,0,0,NOP));
    vecs.push_back(v(0,0,0,1,0,0,0,                  0,B,1,0,0,NOP));
    vecs.push_back(v(0,0,0,0,1,32'h00500293,0,       0,B,0,1,B,32'h00500293));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].rq, vecs[i].rsv, vecs[i].rsd, vecs[i].ifr);
      cyc();
      chk($sformatf("row%0d req_valid", i),  bus.req_valid,  vecs[i].e_reqv);
      chk($sformatf("row%0d req_addr", i),   bus.req_addr,   vecs[i].e_addr);
      chk($sformatf("row%0d resp_ready", i), bus.resp_ready, vecs[i].e_rspr);
      chk($sformatf("row%0d pc_valid", i),   bus.pc_valid,   vecs[i].e_pcv);
      chk($sformatf("row%0d IF_pc", i),      bus.IF_pc,      vecs[i].e_ifpc);
      chk($sformatf("row%0d IF_instr", i),   bus.IF_instr,   vecs[i].e_instr);
    end

    // HOLD: inputs changing mid-cycle must not move the state-decoded outputs
    drive(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 32'h0, 1'b1);
    #1;
    chk("hold comb pc_valid", bus.pc_valid, 1'b1);
    chk("hold comb req_valid", bus.req_valid, 1'b0);
    chk("hold comb resp_ready", bus.resp_ready, 1'b0);
    cyc();
    chk("wrap redirect req_valid", bus.req_valid, 1'b1);
    chk("wrap redirect req_addr", bus.req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap redirect pc_valid", bus.pc_valid, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    cyc();
    chk("wrap wait resp_ready", bus.resp_ready, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'h00600313, 1'b0);
    cyc();
    chk("wrap hold IF_pc", bus.IF_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap hold IF_instr", bus.IF_instr, 32'h00600313);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    cyc();
    chk("wrap next req_valid", bus.req_valid, 1'b1);
    chk("wrap next req_addr", bus.req_addr, 64'h0);

    // Random phase: stream-level scoreboard on retired PCs and issued addresses
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    cyc();
    cyc();
    exp_pc    = B;
    pending   = 1'b0;
    pend_addr = '0;
    retired   = 0;
    for (int c = 0; c < 3000; c++) begin
      logic        rv, rq, rsv, ifr, was_pend;
      logic [63:0] rpc;
      logic [31:0] rsd;
      rv  = ($urandom_range(15) == 0);
      rpc = {$urandom, $urandom};
      rq  = 1'($urandom_range(1));
      ifr = ($urandom_range(2) != 0);
      if (pending) begin
        rsv = 1'($urandom_range(1));
        rsd = memf(pend_addr);
      end else begin
        rsv = ($urandom_range(7) == 0);
        rsd = $urandom;
      end
      drive(1'b0, rv, rpc, rq, rsv, rsd, ifr);

      was_pend = pending;
      if (was_pend) chk("rand resp_ready outstanding", bus.resp_ready, 1'b1);
      if (bus.pc_valid) chk("rand IF_instr", bus.IF_instr, memf(bus.IF_pc));
      if (bus.pc_valid && ifr && !rv) begin
        chk("rand IF_pc", bus.IF_pc, exp_pc);
        exp_pc  = exp_pc + 64'd4;
        retired++;
      end
      if (was_pend && rsv && bus.resp_ready) pending = 1'b0;
      if (bus.req_valid && rq) begin
        chk("rand single outstanding", was_pend, 1'b0);
        if (!rv) chk("rand req_addr", bus.req_addr, exp_pc);
        pending   = 1'b1;
        pend_addr = bus.req_addr;
      end
      if (rv) exp_pc = {rpc[63:2], 2'b00};
      cyc();
    end
    chk("rand progress", 64'(retired > 100), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
- REQ-001: Parameter RESET_PC, default 64'h0000_0000_8000_0000, is the first fetch address after reset.
- REQ-002: Parameter PC_W, default 64, is the PC width.
- REQ-003: Parameter INST_W, default 32, is the instruction width.
- REQ-004: clock, input, 1: the single clock; all state updates on its rising edge.
- REQ-005: reset, input, 1: synchronous, active-high reset.
- REQ-006: redirect_valid, input, 1: branch/jump/trap redirect request.
- REQ-007: redirect_pc, input, PC_W: redirect target.
- REQ-008: req_valid, output, 1: instruction-memory request valid.
- REQ-009: req_ready, input, 1: memory accepts the request.
- REQ-010: req_addr, output, PC_W: fetch address.
- REQ-011: resp_valid, input, 1: memory response valid.
- REQ-012: resp_data, input, INST_W: fetched instruction.
- REQ-013: resp_ready, output, 1: fetch accepts the response.
- REQ-014: pc_valid, output, 1: IF_pc/IF_instr hold a valid instruction for the IF/ID register.
- REQ-015: if_ready, input, 1: the IF/ID register accepts the instruction this cycle.
- REQ-016: IF_pc, output, PC_W: PC of the presented instruction.
- REQ-017: IF_instr, output, INST_W: presented instruction.

Function
- REQ-018: The FSM shall have three states, REQ, WAIT and HOLD, with one outstanding memory request at most.
- REQ-019: In REQ: req_valid=1, req_addr=pc; on req_ready -> WAIT.
- REQ-020: In WAIT: resp_ready=1; on resp_valid with kill=0 -> HOLD, with IF_instr<=resp_data and IF_pc<=pc.
- REQ-021: In WAIT with kill=1, resp_valid shall discard the response, clear kill and go -> REQ.
- REQ-022: In HOLD: pc_valid=1. On if_ready, pc<=pc+4 -> REQ.
- REQ-023: pc_valid, req_valid and resp_ready shall be decoded from state only; they shall not depend combinationally on any input.
- REQ-024: Redirect in REQ shall set pc<=redirect_pc and stay in REQ; req_addr may change before acceptance.
- REQ-025: Redirect in REQ in the same cycle as req_ready shall take effect: pc<=redirect_pc, ->WAIT, kill<=1.
- REQ-026: Redirect in WAIT shall set pc<=redirect_pc and kill<=1; with resp_valid in the same cycle, the response is discarded -> REQ.
- REQ-027: Redirect in HOLD shall drop the held instruction, set pc<=redirect_pc and go -> REQ, even when if_ready=1; pc_valid remains 1 that cycle.
- REQ-028: redirect_pc[1:0] shall be forced to 2'b00 when loaded.
- REQ-029: pc+4 shall wrap modulo 2^PC_W.
- REQ-030: Latency: minimum 3 cycles per instruction (REQ, WAIT, HOLD); the response may arrive earliest the cycle after acceptance.
- REQ-031: resp_valid outside WAIT shall be ignored.

Reset
- REQ-032: Reset shall set state=REQ, pc=RESET_PC, kill=0, IF_pc=0 and IF_instr=32'h0000_0013 (NOP).
- REQ-033: While reset=1, req_valid, resp_ready and pc_valid shall be 0; req_valid rises in the first cycle after reset deasserts.
- REQ-034: Reset mid-transaction shall abandon any outstanding request; a late response is ignored by REQ-031.

Verification
- REQ-035: Reset release with req_ready=1, resp_data=0x00100093 one cycle after acceptance, if_ready=1 -> pc_valid=1, IF_pc=0x80000000, IF_instr=0x00100093; next req_addr=0x80000004.
- REQ-036: HOLD with if_ready=0 for 5 cycles -> pc_valid and IF_pc/IF_instr stable, no new request; if_ready=1 -> request for pc+4.
- REQ-037: Redirect to 0x80001002 during WAIT, then resp_valid -> response discarded, pc_valid never set, next req_addr=0x80001000.
- REQ-038: Redirect to 0x80000100 in HOLD with if_ready=1 -> no pc+4 request; next req_addr=0x80000100.
- REQ-039: pc=0xFFFF_FFFF_FFFF_FFFC accepted -> next req_addr=0.
- REQ-040: Assert reset during WAIT, deliver resp_valid the following cycle -> ignored; req_valid with req_addr=RESET_PC after reset deasserts.
